tick_scheduler: RTL and testbench

- Multi-channel tick scheduler. One shared prescaler produces a base tick every PRESCALE+1 cycles. NCH independent channels count base ticks and emit one-cycle tick pulses, in periodic or one-shot mode.
- Replaces per-consumer free-running clock dividers. Sits between software/control logic (start/stop/config) and the sampling, DSP-rate and timeout consumers.

---
 rtl/tick_scheduler_pkg.sv | 19 +
 rtl/tick_scheduler_if.sv | 34 +++
 rtl/tick_sched_channel.sv | 98 +++++++++
 rtl/tick_scheduler.sv | 74 +++++++
 tb/tb_tick_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and helpers for the multi-channel tick scheduler.
package tick_scheduler_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  // A single-channel build still needs a 1-bit channel select.
  function automatic int ch_idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between the control logic (master) and the scheduler (slave).
interface tick_scheduler_if
  import tick_scheduler_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 16
) ();

  localparam int CH_W = ch_idx_width(NCH);

  logic                 en;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [WIDTH-1:0]     cfg_period;
  logic                 cfg_oneshot;
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       stop;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       busy;

  modport master (
    output en, prescale, cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    input  tick, done, busy
  );

  modport slave (
    input  en, prescale, cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    output tick, done, busy
  );

endinterface

// File: rtl/tick_sched_channel.sv
// One scheduler channel: period/mode registers, base-tick counter and IDLE/RUN FSM.
module tick_sched_channel
  import tick_scheduler_pkg::*;
#(
  parameter int          WIDTH          = 16,
  parameter int unsigned DEFAULT_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o
);

  ch_state_t        state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_val;

  // A write landing on the same edge as a load takes effect for that load.
  assign load_val = cfg_we_i ? cfg_period_i : period_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CH_IDLE;
      mode_q   <= MODE_PERIODIC;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    if (cfg_we_i) begin
      period_d = cfg_period_i;
      mode_d   = cfg_oneshot_i ? MODE_ONESHOT : MODE_PERIODIC;
    end

    unique case (state_q)
      CH_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = CH_RUN;
          cnt_d   = load_val;
        end
      end
      CH_RUN: begin
        // Stop dominates restart and terminal count.
        if (stop_i) begin
          state_d = CH_IDLE;
        end else if (start_i) begin
          cnt_d = load_val;
        end else if (base_tick_i) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            tick_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              done_d  = 1'b1;
              state_d = CH_IDLE;
            end else begin
              cnt_d = load_val;
            end
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  assign tick_o = tick_q;
  assign done_o = done_q;
  assign busy_o = (state_q == CH_RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding NCH independent periodic/one-shot tick channels.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int          NCH            = 4,
  parameter int          WIDTH          = 16,
  parameter int          PRE_WIDTH      = 16,
  parameter int unsigned DEFAULT_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  tick_scheduler_if.slave   bus
);

  localparam int CH_W = ch_idx_width(NCH);

  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 busy_any;
  logic                 base_tick;
  logic [NCH-1:0]       tick_w;
  logic [NCH-1:0]       done_w;
  logic [NCH-1:0]       busy_w;

  assign busy_any  = |busy_w;
  assign base_tick = busy_any & bus.en & (pre_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Parking at prescale while idle gives a start from all-idle a fixed phase.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!busy_any) begin
      pre_cnt_d = bus.prescale;
    end else if (bus.en) begin
      pre_cnt_d = (pre_cnt_q == '0) ? bus.prescale : pre_cnt_q - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic ch_we;

      assign ch_we = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

      tick_sched_channel #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .base_tick_i   (base_tick),
        .cfg_we_i      (ch_we),
        .cfg_period_i  (bus.cfg_period),
        .cfg_oneshot_i (bus.cfg_oneshot),
        .start_i       (bus.start[gi]),
        .stop_i        (bus.stop[gi]),
        .tick_o        (tick_w[gi]),
        .done_o        (done_w[gi]),
        .busy_o        (busy_w[gi])
      );
    end
  endgenerate

  assign bus.tick = tick_w;
  assign bus.done = done_w;
  assign bus.busy = busy_w;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with hand-computed tick/done/busy timelines.
module tb_tick_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tick_scheduler_if #(.NCH(4), .WIDTH(16), .PRE_WIDTH(16)) bus ();

  tick_scheduler #(
    .NCH            (4),
    .WIDTH          (16),
    .PRE_WIDTH      (16),
    .DEFAULT_PERIOD (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int period, input bit oneshot);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 2'(ch);
    bus.cfg_period  = 16'(period);
    bus.cfg_oneshot = oneshot;
    step();
    bus.cfg_we      = 1'b0;
  endtask

  task automatic start_ch(input int ch);
    bus.start = 4'b0001 << ch;
    step();
    bus.start = '0;
  endtask

  task automatic stop_ch(input int ch);
    bus.stop = 4'b0001 << ch;
    step();
    bus.stop = '0;
  endtask

  // Steps edges from..to; bit i of each mask is the expected value after edge Ei.
  task automatic watch(input int ch, input int from, input int to,
                       input logic [63:0] tmask, input logic [63:0] dmask,
                       input logic [63:0] bmask, input string name);
    for (int i = from; i <= to; i++) begin
      step();
      chk($sformatf("%s tick E%0d", name, i), 32'(bus.tick[ch]), 32'(tmask[i]));
      chk($sformatf("%s done E%0d", name, i), 32'(bus.done[ch]), 32'(dmask[i]));
      chk($sformatf("%s busy E%0d", name, i), 32'(bus.busy[ch]), 32'(bmask[i]));
    end
  endtask

  logic [63:0] m0;
  logic [63:0] m1;

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.en          = 1'b1;
    bus.prescale    = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_period  = '0;
    bus.cfg_oneshot = 1'b0;
    bus.start       = '0;
    bus.stop        = '0;

    step();
    step();
    chk("reset tick", 32'(bus.tick), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    step();
    $display("reset: outputs idle");

    // Periodic ch0, period 2, prescale 3: ticks after E12, E24, E36.
    bus.prescale = 16'd3;
    cfg(0, 2, 1'b0);
    start_ch(0);
    chk("t1 busy E0", 32'(bus.busy[0]), 32'h1);
    m0 = (64'd1 << 12) | (64'd1 << 24) | (64'd1 << 36);
    watch(0, 1, 36, m0, 64'd0, {64{1'b1}}, "t1");
    stop_ch(0);
    chk("t1 busy after stop", 32'(bus.busy[0]), 32'h0);
    $display("t1: periodic ch0 period 2 prescale 3");

    // One-shot ch1, period 4, prescale 0: tick+done after E5, busy low from E5.
    bus.prescale = 16'd0;
    cfg(1, 4, 1'b1);
    start_ch(1);
    m0 = 64'd1 << 5;
    watch(1, 1, 15, m0, m0, 64'h1E, "t2");
    $display("t2: one-shot ch1 period 4 prescale 0");

    // Period rewritten to 0 at E5 while running: ticks at E12, E16, E20.
    bus.prescale = 16'd3;
    cfg(0, 2, 1'b0);
    start_ch(0);
    m0 = (64'd1 << 12) | (64'd1 << 16) | (64'd1 << 20);
    for (int i = 1; i <= 20; i++) begin
      bus.cfg_we     = (i == 5);
      bus.cfg_ch     = 2'd0;
      bus.cfg_period = 16'd0;
      step();
      chk($sformatf("t3 tick E%0d", i), 32'(bus.tick[0]), 32'(m0[i]));
    end
    bus.cfg_we = 1'b0;
    stop_ch(0);
    $display("t3: live period rewrite on ch0");

    // Start+stop together while idle keeps ch2 idle.
    bus.start = 4'b0100;
    bus.stop  = 4'b0100;
    step();
    bus.start = '0;
    bus.stop  = '0;
    chk("t4 idle start+stop busy", 32'(bus.busy[2]), 32'h0);
    watch(2, 1, 5, 64'd0, 64'd0, 64'd0, "t4a");

    // One-shot ch2 period 1, prescale 0: terminal count at E2, stop lands there.
    bus.prescale = 16'd0;
    cfg(2, 1, 1'b1);
    start_ch(2);
    step();
    chk("t4 busy E1", 32'(bus.busy[2]), 32'h1);
    chk("t4 tick E1", 32'(bus.tick[2]), 32'h0);
    stop_ch(2);
    chk("t4 stop tick", 32'(bus.tick[2]), 32'h0);
    chk("t4 stop done", 32'(bus.done[2]), 32'h0);
    chk("t4 stop busy", 32'(bus.busy[2]), 32'h0);
    watch(2, 3, 8, 64'd0, 64'd0, 64'd0, "t4b");
    $display("t4: start/stop priority on ch2");

    // Two channels on a shared grid, then en low for E17..E19 shifts by 3.
    bus.prescale = 16'd1;
    cfg(0, 1, 1'b0);
    cfg(1, 3, 1'b0);
    start_ch(0);
    m0 = (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 12) | (64'd1 << 16) |
         (64'd1 << 23) | (64'd1 << 27);
    m1 = (64'd1 << 8) | (64'd1 << 16) | (64'd1 << 27);
    for (int i = 1; i <= 27; i++) begin
      bus.start = (i == 1) ? 4'b0010 : 4'b0000;
      bus.en    = !(i >= 17 && i <= 19);
      step();
      chk($sformatf("t5 ch0 tick E%0d", i), 32'(bus.tick[0]), 32'(m0[i]));
      chk($sformatf("t5 ch1 tick E%0d", i), 32'(bus.tick[1]), 32'(m1[i]));
    end
    bus.start = '0;
    bus.en    = 1'b1;
    $display("t5: shared base grid and enable gap");

    // Asynchronous reset between edges while both ticks are high.
    #2;
    rst = 1'b1;
    #1;
    chk("t6 async tick", 32'(bus.tick), 32'h0);
    chk("t6 async done", 32'(bus.done), 32'h0);
    chk("t6 async busy", 32'(bus.busy), 32'h0);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("t6 quiet tick E%0d", i), 32'(bus.tick), 32'h0);
      chk($sformatf("t6 quiet busy E%0d", i), 32'(bus.busy), 32'h0);
    end
    $display("t6: asynchronous reset mid-run");

    // Reset restored period 0 periodic: with prescale 0 ch0 ticks every cycle.
    bus.prescale = 16'd0;
    start_ch(0);
    watch(0, 1, 4, 64'h1E, 64'd0, 64'h1E, "t7");
    stop_ch(0);
    chk("t7 busy after stop", 32'(bus.busy[0]), 32'h0);
    $display("t7: default period after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
